// File: rtl/calc_ui_pkg.sv
// ============================================================================
//  Module      : calc_ui_pkg
//  Description : Shared UI state codes, operator codes and numpad key constants
//                for the calculator input front end.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package calc_ui_pkg;

    typedef enum logic [2:0] {
        S_CHOOSE_OP   = 3'd0,
        S_INPUT_NUM1  = 3'd1,
        S_INPUT_NUM2  = 3'd2,
        S_SHOW_RESULT = 3'd3
    } ui_state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [3:0] KEY_BKSP  = 4'd9;
    localparam logic [3:0] KEY_ZERO  = 4'd10;
    localparam logic [3:0] KEY_ENTER = 4'd11;

    // Keys 0..8 are digits 1..9; KEY_ZERO is digit 0.
    function automatic logic [3:0] key_to_digit(input logic [3:0] key);
        if (key < 4'd9)
            return key + 4'd1;
        return 4'd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/button_debouncer.sv
// ============================================================================
//  Module      : button_debouncer
//  Description : 2-flop synchronizer, stability counter and rising-edge
//                detector producing a one-cycle press pulse per button press.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable;
    logic               r_stable_q;
    logic               r_press;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_q <= 1'b0;
            r_press    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= btn_raw;
            r_sync2    <= r_sync1;
            r_stable_q <= r_stable;
            r_press    <= r_stable & ~r_stable_q;
            // The new level must be seen DEBOUNCE_CYCLES times in a row.
            if (r_sync2 != r_stable) begin
                if (r_cnt == c_CNT_LAST) begin
                    r_stable <= r_sync2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign press = r_press;

endmodule

`default_nettype wire

// File: rtl/calc_input_controller.sv
// ============================================================================
//  Module      : calc_input_controller
//  Description : Calculator UI front end: button navigation FSM, BCD operand
//                entry and serial BCD-to-binary conversion. Define
//                CALC_WRAP_NAV_EN to make cursor navigation wrap around.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_input_controller
    import calc_ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int MAX_DIGITS      = 4,
    parameter int OPERAND_W       = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    btn_u,
    input  logic                    btn_d,
    input  logic                    btn_l,
    input  logic                    btn_r,
    input  logic                    btn_c,
    output logic [2:0]              state,
    output logic [1:0]              op_selection,
    output logic [3:0]              numpad_selection,
    output logic [4*MAX_DIGITS-1:0] entry_bcd,
    output logic [2:0]              entry_len,
    output logic [OPERAND_W-1:0]    operand_a,
    output logic [OPERAND_W-1:0]    operand_b,
    output logic                    calc_start
);

    localparam int c_ENTRY_W = 4 * MAX_DIGITS;
    localparam int c_IDX_W   = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
    localparam logic [2:0]         c_MAX_LEN  = 3'(MAX_DIGITS);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(MAX_DIGITS - 1);

    logic [4:0] w_btn_raw;
    logic [4:0] w_press;

    // Bit order doubles as priority order: C, U, D, L, R.
    assign w_btn_raw = {btn_r, btn_l, btn_d, btn_u, btn_c};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_raw(w_btn_raw[i]),
            .press  (w_press[i])
        );
    end

    logic w_act_c, w_act_u, w_act_d, w_act_l, w_act_r;
    assign w_act_c = w_press[0];
    assign w_act_u = w_press[1] & ~w_press[0];
    assign w_act_d = w_press[2] & ~|w_press[1:0];
    assign w_act_l = w_press[3] & ~|w_press[2:0];
    assign w_act_r = w_press[4] & ~|w_press[3:0];

    ui_state_t              r_state;
    logic [1:0]             r_op;
    logic [3:0]             r_numpad;
    logic [c_ENTRY_W-1:0]   r_entry_bcd;
    logic [2:0]             r_entry_len;
    logic [OPERAND_W-1:0]   r_operand_a;
    logic [OPERAND_W-1:0]   r_operand_b;
    logic                   r_calc_start;
    logic                   r_converting;
    logic [c_IDX_W-1:0]     r_conv_idx;
    logic [OPERAND_W-1:0]   r_acc;

    logic [c_ENTRY_W-1:0]   w_nib_shift;
    logic [3:0]             w_nibble;
    logic [OPERAND_W-1:0]   w_acc_next;

    // Most significant nibble first: acc = acc*10 + nibble.
    assign w_nib_shift = r_entry_bcd >> {r_conv_idx, 2'b00};
    assign w_nibble    = w_nib_shift[3:0];
    assign w_acc_next  = (r_acc << 3) + (r_acc << 1) + OPERAND_W'(w_nibble);

    logic [3:0] w_col;
    logic [3:0] w_sel_up, w_sel_dn, w_sel_lf, w_sel_rt;

    always_comb begin
        w_col    = r_numpad % 4'd3;
        w_sel_up = r_numpad;
        w_sel_dn = r_numpad;
        w_sel_lf = r_numpad;
        w_sel_rt = r_numpad;
        if (r_numpad >= 4'd3) w_sel_up = r_numpad - 4'd3;
        if (r_numpad <= 4'd8) w_sel_dn = r_numpad + 4'd3;
        if (w_col != 4'd0)    w_sel_lf = r_numpad - 4'd1;
        if (w_col != 4'd2)    w_sel_rt = r_numpad + 4'd1;
`ifdef CALC_WRAP_NAV_EN
        if (r_numpad < 4'd3)  w_sel_up = r_numpad + 4'd9;
        if (r_numpad > 4'd8)  w_sel_dn = r_numpad - 4'd9;
        if (w_col == 4'd0)    w_sel_lf = r_numpad + 4'd2;
        if (w_col == 4'd2)    w_sel_rt = r_numpad - 4'd2;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_CHOOSE_OP;
            r_op         <= OP_ADD;
            r_numpad     <= 4'd0;
            r_entry_bcd  <= '0;
            r_entry_len  <= 3'd0;
            r_operand_a  <= '0;
            r_operand_b  <= '0;
            r_calc_start <= 1'b0;
            r_converting <= 1'b0;
            r_conv_idx   <= '0;
            r_acc        <= '0;
        end else begin
            r_calc_start <= 1'b0;
            if (r_converting) begin
                // Button pulses are deliberately ignored while converting.
                if (r_conv_idx == '0) begin
                    r_converting <= 1'b0;
                    if (r_state == S_INPUT_NUM1) begin
                        r_operand_a <= w_acc_next;
                        r_state     <= S_INPUT_NUM2;
                        r_entry_bcd <= '0;
                        r_entry_len <= 3'd0;
                        r_numpad    <= 4'd0;
                    end else begin
                        r_operand_b  <= w_acc_next;
                        r_calc_start <= 1'b1;
                        r_state      <= S_SHOW_RESULT;
                    end
                end else begin
                    r_acc      <= w_acc_next;
                    r_conv_idx <= r_conv_idx - 1'b1;
                end
            end else begin
                case (r_state)
                    S_CHOOSE_OP: begin
                        if (w_act_c) begin
                            r_state     <= S_INPUT_NUM1;
                            r_numpad    <= 4'd0;
                            r_entry_bcd <= '0;
                            r_entry_len <= 3'd0;
`ifdef CALC_WRAP_NAV_EN
                        end else if (w_act_u || w_act_d) begin
                            r_op[1] <= ~r_op[1];
                        end else if (w_act_l || w_act_r) begin
                            r_op[0] <= ~r_op[0];
                        end
`else
                        end else if (w_act_u) begin
                            r_op[1] <= 1'b0;
                        end else if (w_act_d) begin
                            r_op[1] <= 1'b1;
                        end else if (w_act_l) begin
                            r_op[0] <= 1'b0;
                        end else if (w_act_r) begin
                            r_op[0] <= 1'b1;
                        end
`endif
                    end
                    S_INPUT_NUM1, S_INPUT_NUM2: begin
                        if (w_act_c) begin
                            if (r_numpad == KEY_ENTER) begin
                                r_converting <= 1'b1;
                                r_acc        <= '0;
                                r_conv_idx   <= c_LAST_IDX;
                            end else if (r_numpad == KEY_BKSP) begin
                                if (r_entry_len != 3'd0) begin
                                    r_entry_bcd <= r_entry_bcd >> 4;
                                    r_entry_len <= r_entry_len - 3'd1;
                                end
                            end else if (r_entry_len < c_MAX_LEN) begin
                                r_entry_bcd <= (r_entry_bcd << 4)
                                             | c_ENTRY_W'(key_to_digit(r_numpad));
                                r_entry_len <= r_entry_len + 3'd1;
                            end
                        end else if (w_act_u) begin
                            r_numpad <= w_sel_up;
                        end else if (w_act_d) begin
                            r_numpad <= w_sel_dn;
                        end else if (w_act_l) begin
                            r_numpad <= w_sel_lf;
                        end else if (w_act_r) begin
                            r_numpad <= w_sel_rt;
                        end
                    end
                    S_SHOW_RESULT: begin
                        if (w_act_c) r_state <= S_CHOOSE_OP;
                    end
                    default: r_state <= S_CHOOSE_OP;
                endcase
            end
        end
    end

    assign state            = r_state;
    assign op_selection     = r_op;
    assign numpad_selection = r_numpad;
    assign entry_bcd        = r_entry_bcd;
    assign entry_len        = r_entry_len;
    assign operand_a        = r_operand_a;
    assign operand_b        = r_operand_b;
    assign calc_start       = r_calc_start;

endmodule

`default_nettype wire
